// File: rtl/arm_defs_pkg.sv
// Shared ARM datapath definitions used by the LDM/STM sequencer.
//   LSM_OP     : IR[27:25] opcode class for Load/Store Multiple
//   IR_*       : bit positions of the P/U/W/L/Rn fields inside IR
//   lsm_state_e: sequencer state encoding
package arm_defs_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LIST_W    = 16;
    localparam int unsigned REG_W     = 4;
    localparam int unsigned CNT_W     = 5;

    localparam logic [2:0]  LSM_OP    = 3'b100;

    localparam int unsigned IR_OP_LSB = 25;
    localparam int unsigned IR_P      = 24;
    localparam int unsigned IR_U      = 23;
    localparam int unsigned IR_W      = 21;
    localparam int unsigned IR_L      = 20;
    localparam int unsigned IR_RN_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_FINISH = 2'd2
    } lsm_state_e;

endpackage

// File: rtl/reg_list_popcount.sv
// Counts the set bits of a 16-entry register list (combinational).
//   list_i  : register list IR[15:0]
//   count_o : number of listed registers, 0..16
module reg_list_popcount
    import arm_defs_pkg::*;
(
    input  logic [LIST_W-1:0] list_i,
    output logic [CNT_W-1:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(LIST_W); i++) begin
            count_o = count_o + CNT_W'(list_i[i]);
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Walks the register list of an ARM LDM/STM, issuing one memory transfer per
// listed register with ascending addresses, then a base writeback strobe.
//   CLK, RESET_N      : clock, async active-low reset
//   START, IR, RN_VALUE : request, instruction and base value (sampled in IDLE)
//   MEM_DONE          : memory completes the current transfer
//   BUSY              : operation in progress (XFER or FINISH)
//   MEM_REQ/RW/ADDR   : memory transfer request, direction (1=load), address
//   REG_ADDR, REG_WE  : register-file index and write strobe (REG_WE comb.)
//   WB_EN/REG/VALUE   : base writeback strobe, register and value
//   DONE              : one-cycle completion pulse
module ldm_stm_sequencer
    import arm_defs_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [DATA_W-1:0] IR,
    input  logic [DATA_W-1:0] RN_VALUE,
    input  logic              MEM_DONE,
    output logic              BUSY,
    output logic              MEM_REQ,
    output logic              MEM_RW,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic [REG_W-1:0]  REG_ADDR,
    output logic              REG_WE,
    output logic              WB_EN,
    output logic [REG_W-1:0]  WB_REG,
    output logic [DATA_W-1:0] WB_VALUE,
    output logic              DONE
);

    lsm_state_e        state_q, state_d;
    logic [LIST_W-1:0] list_q, list_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wbv_q, wbv_d;
    logic [REG_W-1:0]  rn_q, rn_d;
    logic              l_q, l_d;
    logic              wbok_q, wbok_d;

    logic [CNT_W-1:0]  n_c;
    logic [DATA_W-1:0] blk_c;
    logic [REG_W-1:0]  low_c;
    logic [REG_W-1:0]  ir_rn_c;
    logic              accept_c;

    reg_list_popcount u_popcount (
        .list_i  (IR[LIST_W-1:0]),
        .count_o (n_c)
    );

    assign blk_c    = DATA_W'(n_c) << 2;
    assign ir_rn_c  = IR[IR_RN_LSB +: REG_W];
    assign accept_c = START && (IR[IR_OP_LSB +: 3] == LSM_OP);

    // Lowest set bit of the remaining list; scanning downward lets the lowest win.
    always_comb begin
        low_c = '0;
        for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
            if (list_q[i]) low_c = REG_W'(i);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        list_d  = list_q;
        addr_d  = addr_q;
        wbv_d   = wbv_q;
        rn_d    = rn_q;
        l_d     = l_q;
        wbok_d  = wbok_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    list_d = IR[LIST_W-1:0];
                    l_d    = IR[IR_L];
                    rn_d   = ir_rn_c;
                    wbv_d  = IR[IR_U] ? (RN_VALUE + blk_c) : (RN_VALUE - blk_c);
                    // A load that overwrites the base keeps the loaded value.
                    wbok_d = IR[IR_W] && (n_c != '0) && !(IR[IR_L] && IR[ir_rn_c]);
                    // Transfers always ascend, so start at the lowest address.
                    case ({IR[IR_P], IR[IR_U]})
                        2'b01:   addr_d = RN_VALUE;
                        2'b11:   addr_d = RN_VALUE + 32'd4;
                        2'b00:   addr_d = RN_VALUE - blk_c + 32'd4;
                        default: addr_d = RN_VALUE - blk_c;
                    endcase
                    state_d = (IR[LIST_W-1:0] == '0) ? ST_FINISH : ST_XFER;
                end
            end
            ST_XFER: begin
                if (MEM_DONE) begin
                    list_d = list_q & (list_q - LIST_W'(1));
                    addr_d = addr_q + 32'd4;
                    if (list_d == '0) state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            list_q  <= '0;
            addr_q  <= '0;
            wbv_q   <= '0;
            rn_q    <= '0;
            l_q     <= 1'b0;
            wbok_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            addr_q  <= addr_d;
            wbv_q   <= wbv_d;
            rn_q    <= rn_d;
            l_q     <= l_d;
            wbok_q  <= wbok_d;
        end
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign MEM_REQ  = (state_q == ST_XFER);
    assign MEM_RW   = MEM_REQ && l_q;
    assign MEM_ADDR = addr_q;
    assign REG_ADDR = low_c;
    assign REG_WE   = MEM_REQ && l_q && MEM_DONE;
    assign DONE     = (state_q == ST_FINISH);
    assign WB_EN    = DONE && wbok_q;
    assign WB_REG   = rn_q;
    assign WB_VALUE = wbv_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: directed scenarios plus random
// LDM/STM operations compared against a list/queue reference model.
module tb_ldm_stm_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [31:0] IR;
    logic [31:0] RN_VALUE;
    logic        MEM_DONE;
    logic        BUSY, MEM_REQ, MEM_RW, REG_WE, WB_EN, DONE;
    logic [31:0] MEM_ADDR, WB_VALUE;
    logic [3:0]  REG_ADDR, WB_REG;

    int tests  = 0;
    int failed = 0;

    ldm_stm_sequencer dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .START    (START),
        .IR       (IR),
        .RN_VALUE (RN_VALUE),
        .MEM_DONE (MEM_DONE),
        .BUSY     (BUSY),
        .MEM_REQ  (MEM_REQ),
        .MEM_RW   (MEM_RW),
        .MEM_ADDR (MEM_ADDR),
        .REG_ADDR (REG_ADDR),
        .REG_WE   (REG_WE),
        .WB_EN    (WB_EN),
        .WB_REG   (WB_REG),
        .WB_VALUE (WB_VALUE),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},   32'(BUSY),     32'd0);
        chk({tag, ".req"},    32'(MEM_REQ),  32'd0);
        chk({tag, ".rw"},     32'(MEM_RW),   32'd0);
        chk({tag, ".addr"},   MEM_ADDR,      32'd0);
        chk({tag, ".reg"},    32'(REG_ADDR), 32'd0);
        chk({tag, ".regwe"},  32'(REG_WE),   32'd0);
        chk({tag, ".wben"},   32'(WB_EN),    32'd0);
        chk({tag, ".wbreg"},  32'(WB_REG),   32'd0);
        chk({tag, ".wbval"},  WB_VALUE,      32'd0);
        chk({tag, ".done"},   32'(DONE),     32'd0);
    endtask

    // Issue one START and follow the whole operation cycle by cycle.
    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic run_op(input string name, input logic [31:0] ir, input logic [31:0] rn,
                          input int fixed_stall, input int rand_pct, input bit noise);
        logic [15:0] list;
        logic [3:0]  rnf;
        logic        p, u, w, l, is_lsm, exp_wben, done;
        logic [31:0] lo, exp_wbv;
        int          regs[$];
        logic [31:0] addrs[$];
        int          n, cyc, stalls;

        list   = ir[15:0];
        rnf    = ir[19:16];
        p      = ir[24];
        u      = ir[23];
        w      = ir[21];
        l      = ir[20];
        is_lsm = (ir[27:25] == 3'b100);
        for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
        n = regs.size();
        // Lowest address of the block; transfers climb from there.
        if (u) lo = p ? rn + 32'd4 : rn;
        else   lo = p ? rn - 32'(4 * n) : rn - 32'(4 * n) + 32'd4;
        for (int k = 0; k < n; k++) addrs.push_back(lo + 32'(4 * k));
        exp_wbv  = u ? rn + 32'(4 * n) : rn - 32'(4 * n);
        exp_wben = w && (n > 0) && !(l && list[rnf]);

        START    = 1'b1;
        IR       = ir;
        RN_VALUE = rn;
        MEM_DONE = 1'b0;
        @(posedge CLK); #1;
        START    = 1'b0;
        IR       = $urandom;
        RN_VALUE = $urandom;
        cyc      = 1;

        if (!is_lsm) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge CLK);
                chk({name, ".ign_busy"}, 32'(BUSY),    32'd0);
                chk({name, ".ign_req"},  32'(MEM_REQ), 32'd0);
                chk({name, ".ign_done"}, 32'(DONE),    32'd0);
                @(posedge CLK); #1;
            end
            return;
        end

        while (addrs.size() > 0) begin
            stalls = 0;
            forever begin
                done = (stalls >= fixed_stall) &&
                       ((rand_pct == 0) || ($urandom_range(99) >= 32'(rand_pct)));
                if (stalls >= fixed_stall + 8) done = 1'b1;
                MEM_DONE = done;
                if (noise) begin
                    START = 1'($urandom_range(1));
                    IR    = {4'hE, 3'b100, 9'($urandom), 16'($urandom)};
                end
                @(negedge CLK);
                chk({name, ".x_req"},   32'(MEM_REQ),  32'd1);
                chk({name, ".x_busy"},  32'(BUSY),     32'd1);
                chk({name, ".x_rw"},    32'(MEM_RW),   32'(l));
                chk({name, ".x_addr"},  MEM_ADDR,      addrs[0]);
                chk({name, ".x_reg"},   32'(REG_ADDR), 32'(regs[0]));
                chk({name, ".x_regwe"}, 32'(REG_WE),   32'(l && done));
                chk({name, ".x_done"},  32'(DONE),     32'd0);
                chk({name, ".x_wben"},  32'(WB_EN),    32'd0);
                @(posedge CLK); #1;
                cyc++;
                if (done) break;
                stalls++;
            end
            void'(addrs.pop_front());
            void'(regs.pop_front());
        end

        MEM_DONE = 1'($urandom_range(1));
        if (noise) START = 1'($urandom_range(1));
        @(negedge CLK);
        chk({name, ".f_done"},  32'(DONE),    32'd1);
        chk({name, ".f_busy"},  32'(BUSY),    32'd1);
        chk({name, ".f_req"},   32'(MEM_REQ), 32'd0);
        chk({name, ".f_regwe"}, 32'(REG_WE),  32'd0);
        chk({name, ".f_wben"},  32'(WB_EN),   32'(exp_wben));
        chk({name, ".f_wbreg"}, 32'(WB_REG),  32'(rnf));
        if (n > 0) chk({name, ".f_wbval"}, WB_VALUE, exp_wbv);
        if (fixed_stall == 0 && rand_pct == 0) chk({name, ".f_cycle"}, 32'(cyc), 32'(n + 1));
        @(posedge CLK); #1;
        START    = 1'b0;
        MEM_DONE = 1'b0;
        chk({name, ".i_busy"}, 32'(BUSY),    32'd0);
        chk({name, ".i_done"}, 32'(DONE),    32'd0);
        chk({name, ".i_wben"}, 32'(WB_EN),   32'd0);
        chk({name, ".i_req"},  32'(MEM_REQ), 32'd0);
    endtask

    initial begin
        logic [31:0] rir, rrn, lmask;

        RESET_N  = 1'b0;
        START    = 1'b0;
        IR       = '0;
        RN_VALUE = '0;
        MEM_DONE = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        run_op("stmia",   32'hE8A1000E, 32'h0000_0100, 0, 0, 1'b0);
        run_op("ldmdb",   32'hE93D8011, 32'h0000_0200, 0, 0, 1'b0);
        run_op("ldmib",   32'hE9920020, 32'h0000_0040, 3, 0, 1'b0);
        run_op("ldmia_b", 32'hE8B00003, 32'h0000_1000, 0, 0, 1'b0);
        run_op("empty",   32'hE8A10000, 32'h0000_0300, 0, 0, 1'b0);
        run_op("nonlsm",  32'hE0810002, 32'h0000_0300, 0, 0, 1'b0);

        // Abort during the second transfer of the STMIA scenario.
        START    = 1'b1;
        IR       = 32'hE8A1000E;
        RN_VALUE = 32'h0000_0100;
        @(posedge CLK); #1;
        START    = 1'b0;
        MEM_DONE = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst.pre_addr", MEM_ADDR, 32'h0000_0104);
        #1 RESET_N = 1'b0;
        #1;
        chk_all_zero("rst.now");
        repeat (2) begin
            @(posedge CLK); #1;
            chk("rst.hold_done", 32'(DONE),  32'd0);
            chk("rst.hold_wben", 32'(WB_EN), 32'd0);
        end
        RESET_N  = 1'b1;
        MEM_DONE = 1'b0;
        @(posedge CLK); #1;
        run_op("stmia_again", 32'hE8A1000E, 32'h0000_0100, 0, 0, 1'b0);

        // Random LDM/STM with random stalls, base values and busy-time STARTs.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(3))
                0:       lmask = 32'h0000_0000 | (32'h1 << $urandom_range(15));
                1:       lmask = 32'h0000_FFFF;
                default: lmask = $urandom;
            endcase
            rir = {4'hE, 3'b100, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom),
                   1'($urandom), 4'($urandom), 16'($urandom & lmask)};
            if (t % 10 == 9) rir[15:0] = 16'h0000;
            rrn = $urandom;
            if (t % 8 == 3) rrn = 32'hFFFF_FFF8;
            run_op($sformatf("rnd%0d", t), rir, rrn, 0, (t % 3 == 0) ? 0 : 35, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
